// File: rtl/rv_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath.
interface rv_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic [31:0]      instr;
    logic             stall;
    logic             ir_load;
    logic             alu_en;
    logic             reg_we;
    logic             pc_en;
    logic [2:0]       state;
    logic             halted;
    logic [1:0]       cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  imem_ack, instr, stall,
        output imem_req, ir_load, alu_en, reg_we, pc_en, state, halted, cause, instret
    );

    modport slave (
        output imem_ack, instr, stall,
        input  imem_req, ir_load, alu_en, reg_we, pc_en, state, halted, cause, instret
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with illegal-opcode and
// fetch-timeout traps and a retired-instruction counter.
module rv_multicycle_ctrl #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  reset,
    rv_multicycle_ctrl_if.master bus
);
    localparam int unsigned TMO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StWriteback = 3'd3,
        StTrap      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic       op_legal;
    logic       rd_nz;
    logic       unused_instr;

    assign opcode       = bus.instr[6:0];
    assign op_legal     = (opcode == OP_R) || (opcode == OP_I);
    assign rd_nz        = |bus.instr[11:7];
    assign unused_instr = ^bus.instr[31:12];

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        unique case (state_q)
            StFetch: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (bus.imem_ack) begin
                    state_d = StDecode;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StDecode: begin
                if (op_legal) begin
                    state_d = StExecute;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'd1;
                end
            end
            StExecute: begin
                if (!bus.stall) state_d = StWriteback;
            end
            StWriteback: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_load  = 1'b0;
        bus.alu_en   = 1'b0;
        bus.reg_we   = 1'b0;
        bus.pc_en    = 1'b0;
        bus.halted   = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ack;
            end
            StExecute: begin
                bus.alu_en = 1'b1;
            end
            StWriteback: begin
                bus.alu_en = 1'b1;
                bus.pc_en  = 1'b1;
                bus.reg_we = rd_nz;
            end
            StTrap: begin
                bus.halted = 1'b1;
            end
            default: begin
            end
        endcase
        // Reset squashes strobes immediately, before the state register clears.
        if (reset) begin
            bus.imem_req = 1'b0;
            bus.ir_load  = 1'b0;
            bus.alu_en   = 1'b0;
            bus.reg_we   = 1'b0;
            bus.pc_en    = 1'b0;
            bus.halted   = 1'b0;
        end
    end

    assign bus.state   = state_q;
    assign bus.cause   = cause_q;
    assign bus.instret = instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            tmo_q     <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench: transaction-level model expands each instruction into its expected
// per-cycle outputs; every cycle is compared, plus literal spot checks.
module tb_rv_multicycle_ctrl;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_TRAP  = 3'd4;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDZ = 32'h00500013;
    localparam logic [31:0] I_ADDI = 32'h00500293;
    localparam logic [31:0] I_LW   = 32'h0000A103;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic [31:0] ins;
    } stim_t;

    typedef struct {
        logic [2:0]       st;
        logic             req, irl, alu, we, pc, halt;
        logic [1:0]       cause;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic clk;
    logic reset;
    rv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rv_multicycle_ctrl #(
        .CNT_W        (CNT_W),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t sq[$];
    exp_t  eq[$];
    int    m_ret;
    int    m_cause;
    int    n_checks;
    int    n_pass;
    int    cyc;

    task automatic push(input logic rst, input logic ack, input logic stall,
                        input logic [31:0] ins, input logic [2:0] st, input logic req,
                        input logic irl, input logic alu, input logic we, input logic pc,
                        input logic halt);
        stim_t s;
        exp_t  e;
        s.rst = rst; s.ack = ack; s.stall = stall; s.ins = ins;
        e.st = st; e.req = req; e.irl = irl; e.alu = alu; e.we = we; e.pc = pc;
        e.halt = halt; e.cause = 2'(m_cause); e.ret = CNT_W'(m_ret);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    // One instruction: waits = FETCH cycles before ack, stalls = extra EXECUTE cycles,
    // abort_exec > 0 stops after that many stalled EXECUTE cycles (reset follows).
    task automatic run_instr(input logic [31:0] ins, input int waits, input int stalls,
                             input int abort_exec);
        logic [6:0] op;
        logic [4:0] rd;
        op = ins[6:0];
        rd = ins[11:7];
        for (int i = 0; i < waits && i < TMO; i++)
            push(1'b0, 1'b0, 1'b1, ins, S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (waits >= TMO) begin
            m_cause = 2;
            return;
        end
        push(1'b0, 1'b1, 1'b1, ins, S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, ins, S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!(op == 7'b0110011 || op == 7'b0010011)) begin
            m_cause = 1;
            return;
        end
        if (abort_exec > 0) begin
            for (int k = 0; k < abort_exec; k++)
                push(1'b0, 1'b1, 1'b1, ins, S_EXE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int k = 0; k < stalls; k++)
            push(1'b0, 1'b1, 1'b1, ins, S_EXE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, ins, S_EXE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, ins, S_WB, 1'b0, 1'b0, 1'b1, rd != 5'd0, 1'b1, 1'b0);
        m_ret = (m_ret + 1) % (1 << CNT_W);
    endtask

    task automatic trap_cycles(input int n);
        logic [1:0] t;
        for (int i = 0; i < n; i++) begin
            t = 2'(i);
            push(1'b0, t[0], t[1], I_ADD, S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // First reset cycle still shows the pre-reset state/cause/count.
    task automatic reset_cycles(input int n, input logic [2:0] first_st);
        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                m_ret   = 0;
                m_cause = 0;
            end
            push(1'b1, 1'b1, 1'b1, I_ADD, (i == 0) ? first_st : S_FETCH,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        m_ret   = 0;
        m_cause = 0;
    endtask

    task automatic compare(input exp_t e);
        logic ok;
        ok = (bus.state === e.st) && (bus.imem_req === e.req) && (bus.ir_load === e.irl)
          && (bus.alu_en === e.alu) && (bus.reg_we === e.we) && (bus.pc_en === e.pc)
          && (bus.halted === e.halt) && (bus.cause === e.cause) && (bus.instret === e.ret);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL cycle %0d: got st=%0d req=%b irl=%b alu=%b we=%b pc=%b halt=%b cause=%0d ret=%0d; exp st=%0d req=%b irl=%b alu=%b we=%b pc=%b halt=%b cause=%0d ret=%0d",
                      cyc, bus.state, bus.imem_req, bus.ir_load, bus.alu_en, bus.reg_we,
                      bus.pc_en, bus.halted, bus.cause, bus.instret, e.st, e.req, e.irl,
                      e.alu, e.we, e.pc, e.halt, e.cause, e.ret);
    endtask

    task automatic lit(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic replay();
        stim_t s;
        exp_t  e;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(negedge clk);
            reset         = s.rst;
            bus.imem_ack  = s.ack;
            bus.stall     = s.stall;
            bus.instr     = s.ins;
            #2;
            compare(e);
            cyc++;
        end
        // Land just after the next edge so registered outputs can be spot-checked.
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; m_ret = 0; m_cause = 0;
        reset = 1'b1; bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.instr = I_ADD;
        @(posedge clk);

        // 1: nominal add x3,x1,x2
        reset_cycles(1, S_FETCH);
        run_instr(I_ADD, 0, 0, 0);
        lit("model_nominal_len", sq.size(), 5);
        replay();
        lit("t1_state", int'(bus.state), 0);
        lit("t1_instret", int'(bus.instret), 1);

        // 2: rd = x0, no reg_we
        run_instr(I_ADDZ, 0, 0, 0);
        replay();
        lit("t2_instret", int'(bus.instret), 2);

        // 3: three stall cycles, seven-cycle instruction
        run_instr(I_ADD, 0, 3, 0);
        lit("model_stall_len", sq.size(), 7);
        replay();
        lit("t3_instret", int'(bus.instret), 3);

        // fetch wait of two cycles
        run_instr(I_ADDI, 2, 0, 0);
        replay();
        lit("wait_instret", int'(bus.instret), 4);

        // 4: illegal opcode trap, held 20 cycles, then reset
        run_instr(I_LW, 0, 0, 0);
        trap_cycles(20);
        replay();
        lit("t4_halted", int'(bus.halted), 1);
        lit("t4_cause", int'(bus.cause), 1);
        lit("t4_state", int'(bus.state), 4);
        reset_cycles(2, S_TRAP);
        replay();
        lit("t4_rst_state", int'(bus.state), 0);
        lit("t4_rst_cause", int'(bus.cause), 0);

        // 5: fetch timeout, then ack in the final allowed cycle
        run_instr(I_ADD, TMO, 0, 0);
        trap_cycles(3);
        replay();
        lit("t5_cause", int'(bus.cause), 2);
        lit("t5_state", int'(bus.state), 4);
        reset_cycles(1, S_TRAP);
        run_instr(I_ADD, TMO - 1, 0, 0);
        replay();
        lit("t5_late_ack_instret", int'(bus.instret), 1);

        // 6: reset during EXECUTE of the third instruction
        reset_cycles(1, S_FETCH);
        run_instr(I_ADD, 0, 0, 0);
        run_instr(I_ADDI, 1, 1, 0);
        run_instr(I_ADD, 0, 0, 2);
        reset_cycles(2, S_EXE);
        replay();
        lit("t6_state", int'(bus.state), 0);
        lit("t6_instret", int'(bus.instret), 0);

        // counter wrap at 2^CNT_W
        for (int i = 0; i < 16; i++)
            run_instr((i % 2 == 0) ? I_ADD : I_ADDI, i % 3, i % 2, 0);
        replay();
        lit("wrap_instret", int'(bus.instret), 0);
        lit("wrap_state", int'(bus.state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
